// File: rtl/ccx_mem_responder.sv
// Memory-side responder: req/gnt handshake, programmable grant wait states, one-cycle response.
// Optional random grant stalls when CCX_MEM_RESPONDER_RAND_STALL_EN is defined.
module ccx_mem_responder #(
   parameter int unsigned        AW          = 39,
   parameter int unsigned        DW          = 64,
   parameter int unsigned        DEPTH       = 8192,
   parameter logic [AW-1:0]      BASE        = 39'h0000010000,
   parameter int unsigned        WAIT_CYCLES = 0,
   parameter logic [15:0]        LFSR_SEED   = 16'hACE1
) (
   input  logic            g_clk,
   input  logic            g_resetn,
   input  logic            mem_req,
   output logic            mem_gnt,
   input  logic            mem_wen,
   input  logic [DW/8-1:0] mem_strb,
   input  logic [AW-1:0]   mem_addr,
   input  logic [DW-1:0]   mem_wdata,
   output logic [DW-1:0]   mem_rdata,
   output logic            mem_err
);

   localparam int unsigned   IW       = $clog2(DEPTH);
   localparam logic [AW-1:0] WIN_MASK = AW'(DEPTH * 8 - 1);
   localparam logic [3:0]    WAIT_MAX = 4'(WAIT_CYCLES);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [3:0]      wait_cnt_q, wait_cnt_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            err_q, err_d;
   logic [DW-1:0]   mem_q [DEPTH];

   logic            stall_s;
   logic            gnt_s;
   logic            in_range_s;
   logic [AW-1:0]   offset_s;
   logic [IW-1:0]   index_s;
   logic            unused_s;

   function automatic logic in_window(input logic [AW-1:0] addr);
      return (addr & ~WIN_MASK) == BASE;
   endfunction

`ifdef CCX_MEM_RESPONDER_RAND_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Free-running Fibonacci LFSR, taps 16,14,13,11
   always_comb begin
      lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      stall_s = (lfsr_q[1:0] == 2'b00);
   end

   // LFSR state register
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   assign stall_s = 1'b0;
`endif

   // Decode, grant, FSM/counter next state and response next state
   always_comb begin
      offset_s   = mem_addr - BASE;
      index_s    = offset_s[IW+2:3];
      unused_s   = ^{offset_s[AW-1:IW+3], offset_s[2:0]};
      in_range_s = in_window(mem_addr);
      gnt_s      = mem_req && (wait_cnt_q == WAIT_MAX) && !stall_s;

      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      rdata_d    = rdata_q;
      err_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (mem_req && !gnt_s) begin
               state_d = WAIT;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (gnt_s || !mem_req) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT;
            end
         end
         default: state_d = IDLE;
      endcase

      // Stall cycles keep the count; only grant or a dropped request clears it
      if (!mem_req || gnt_s) begin
         wait_cnt_d = 4'd0;
      end else if (wait_cnt_q != WAIT_MAX) begin
         wait_cnt_d = wait_cnt_q + 4'd1;
      end else begin
         wait_cnt_d = wait_cnt_q;
      end

      if (gnt_s) begin
         if (!in_range_s) begin
            err_d   = 1'b1;
            rdata_d = {DW{1'b0}};
         end else if (mem_wen) begin
            rdata_d = {DW{1'b0}};
         end else begin
            rdata_d = mem_q[index_s];
         end
      end else begin
         rdata_d = rdata_q;
      end
   end

   // Control and response registers
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         state_q    <= IDLE;
         wait_cnt_q <= 4'd0;
         rdata_q    <= {DW{1'b0}};
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
      end
   end

   // Byte-strobed array write; contents are not reset
   always_ff @(posedge g_clk) begin
      if (g_resetn && gnt_s && in_range_s && mem_wen) begin
         for (int k = 0; k < DW/8; k++) begin
            if (mem_strb[k]) begin
               mem_q[index_s][k*8 +: 8] <= mem_wdata[k*8 +: 8];
            end
         end
      end
   end

   assign mem_gnt   = gnt_s;
   assign mem_rdata = rdata_q;
   assign mem_err   = err_q;

endmodule

// File: tb/tb_ccx_mem_responder.sv
// Directed bench: three responders (0, 3 and 2 wait states) sharing request fields.
module tb_ccx_mem_responder;

   logic        g_clk = 1'b0;
   logic        g_resetn, resetn2;
   logic        req0, req3, req2;
   logic        gnt0, gnt3, gnt2;
   logic        wen;
   logic [7:0]  strb;
   logic [38:0] addr;
   logic [63:0] wdata;
   logic [63:0] rdata0, rdata3, rdata2;
   logic        err0, err3, err2;

   int checks   = 0;
   int failures = 0;

   always #5 g_clk = ~g_clk;

   ccx_mem_responder #(.WAIT_CYCLES(0)) u0 (
      .g_clk(g_clk), .g_resetn(g_resetn), .mem_req(req0), .mem_gnt(gnt0),
      .mem_wen(wen), .mem_strb(strb), .mem_addr(addr), .mem_wdata(wdata),
      .mem_rdata(rdata0), .mem_err(err0));

   ccx_mem_responder #(.WAIT_CYCLES(3)) u3 (
      .g_clk(g_clk), .g_resetn(g_resetn), .mem_req(req3), .mem_gnt(gnt3),
      .mem_wen(wen), .mem_strb(strb), .mem_addr(addr), .mem_wdata(wdata),
      .mem_rdata(rdata3), .mem_err(err3));

   ccx_mem_responder #(.WAIT_CYCLES(2)) u2 (
      .g_clk(g_clk), .g_resetn(resetn2), .mem_req(req2), .mem_gnt(gnt2),
      .mem_wen(wen), .mem_strb(strb), .mem_addr(addr), .mem_wdata(wdata),
      .mem_rdata(rdata2), .mem_err(err2));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge g_clk);
      #1;
   endtask

   // u0 access: set fields, expect same-cycle grant, then check the response
   task automatic acc0(input string tag, input logic w, input logic [38:0] a,
                       input logic [63:0] d, input logic [7:0] s,
                       input logic [63:0] exp_rdata, input logic exp_err);
      req0 = 1'b1; wen = w; addr = a; wdata = d; strb = s;
      #1;
      check({tag, "_gnt"}, {63'd0, gnt0}, 64'd1);
      step();
      check({tag, "_err"}, {63'd0, err0}, {63'd0, exp_err});
      check({tag, "_rdata"}, rdata0, exp_rdata);
   endtask

   initial begin
      g_resetn = 1'b0; resetn2 = 1'b0;
      req0 = 1'b0; req3 = 1'b0; req2 = 1'b0;
      wen = 1'b0; strb = 8'h00; addr = 39'h0; wdata = 64'h0;
      step(); step();
      g_resetn = 1'b1; resetn2 = 1'b1;
      #1;
      check("rst_rdata0", rdata0, 64'd0);
      check("rst_err0", {63'd0, err0}, 64'd0);
      check("rst_gnt0", {63'd0, gnt0}, 64'd0);
      check("rst_rdata3", rdata3, 64'd0);
      check("rst_err2", {63'd0, err2}, 64'd0);

      // Zero-wait: preload word 0 then read it back-to-back
      acc0("pre_w0", 1'b1, 39'h10000, 64'h0123456789ABCDEF, 8'hFF, 64'd0, 1'b0);
      acc0("rd_w0", 1'b0, 39'h10000, 64'd0, 8'h00, 64'h0123456789ABCDEF, 1'b0);

      // Strobed write over zeros
      acc0("clr_w1", 1'b1, 39'h10008, 64'd0, 8'hFF, 64'd0, 1'b0);
      acc0("strb_w1", 1'b1, 39'h10008, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 64'd0, 1'b0);
      acc0("rd_w1", 1'b0, 39'h10008, 64'd0, 8'h00, 64'h00000000FFFFFFFF, 1'b0);
      acc0("noop_w1", 1'b1, 39'h1000F, 64'h1111111111111111, 8'h00, 64'd0, 1'b0);
      acc0("rd_w1b", 1'b0, 39'h1000D, 64'd0, 8'h00, 64'h00000000FFFFFFFF, 1'b0);

      // Out of range: write dropped (would alias word 0), read errors
      acc0("oor_wr", 1'b1, 39'h20000, 64'hDEADBEEFDEADBEEF, 8'hFF, 64'd0, 1'b1);
      acc0("oor_rd", 1'b0, 39'h20000, 64'd0, 8'h00, 64'd0, 1'b1);
      acc0("oor_lo", 1'b0, 39'h0FFF8, 64'd0, 8'h00, 64'd0, 1'b1);
      acc0("rd_w0_kept", 1'b0, 39'h10000, 64'd0, 8'h00, 64'h0123456789ABCDEF, 1'b0);

      // Last word of the window
      acc0("top_wr", 1'b1, 39'h1FFF8, 64'hA5A5A5A55A5A5A5A, 8'hFF, 64'd0, 1'b0);
      acc0("top_rd", 1'b0, 39'h1FFF8, 64'd0, 8'h00, 64'hA5A5A5A55A5A5A5A, 1'b0);

      // Idle cycle: no error, data held
      req0 = 1'b0;
      step();
      check("idle_err", {63'd0, err0}, 64'd0);
      check("idle_hold", rdata0, 64'hA5A5A5A55A5A5A5A);

      // Back-to-back: write A, read A, read OOR, read A
      acc0("b2b_wr", 1'b1, 39'h10010, 64'hCAFEF00D12345678, 8'hFF, 64'd0, 1'b0);
      acc0("b2b_rd", 1'b0, 39'h10010, 64'd0, 8'h00, 64'hCAFEF00D12345678, 1'b0);
      acc0("b2b_oor", 1'b0, 39'h20000, 64'd0, 8'h00, 64'd0, 1'b1);
      acc0("b2b_rd2", 1'b0, 39'h10010, 64'd0, 8'h00, 64'hCAFEF00D12345678, 1'b0);
      req0 = 1'b0;

      // Three wait states: grant on the 4th request cycle
      wen = 1'b0; addr = 39'h20000; strb = 8'h00;
      req3 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("w3_wait%0d", i), {63'd0, gnt3}, 64'd0);
         step();
         check($sformatf("w3_noerr%0d", i), {63'd0, err3}, 64'd0);
      end
      check("w3_gnt", {63'd0, gnt3}, 64'd1);
      step();
      req3 = 1'b0;
      check("w3_rsp_err", {63'd0, err3}, 64'd1);
      check("w3_rsp_rdata", rdata3, 64'd0);

      // Abandon after 2 cycles, then the count restarts from zero
      req3 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         check($sformatf("ab_wait%0d", i), {63'd0, gnt3}, 64'd0);
         step();
      end
      req3 = 1'b0;
      step();
      check("ab_noerr", {63'd0, err3}, 64'd0);
      req3 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("re_wait%0d", i), {63'd0, gnt3}, 64'd0);
         step();
      end
      check("re_gnt", {63'd0, gnt3}, 64'd1);
      step();
      req3 = 1'b0;
      check("re_rsp_err", {63'd0, err3}, 64'd1);

      // Reset mid-wait on the two-wait-state instance
      req2 = 1'b1;
      #1;
      check("rw_wait0", {63'd0, gnt2}, 64'd0);
      step();
      resetn2 = 1'b0;
      step();
      check("rw_gnt", {63'd0, gnt2}, 64'd0);
      check("rw_err", {63'd0, err2}, 64'd0);
      check("rw_rdata", rdata2, 64'd0);
      resetn2 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         check($sformatf("rw_post_wait%0d", i), {63'd0, gnt2}, 64'd0);
         step();
      end
      check("rw_post_gnt", {63'd0, gnt2}, 64'd1);
      step();
      req2 = 1'b0;
      check("rw_post_err", {63'd0, err2}, 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
